// File: rtl/pipe_stats_unit_pkg.sv
// Shared types for the pipeline statistics unit: opcode map, instruction
// classes, FSM states and the opcode classifier used by the decoder.
package pipe_stats_unit_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_SUB  = 6'b000001,
        OP_MUL  = 6'b000010,
        OP_DIV  = 6'b000011,
        OP_ADDI = 6'b000100,
        OP_MULI = 6'b000101,
        OP_OR   = 6'b000110,
        OP_AND  = 6'b000111,
        OP_XOR  = 6'b001000,
        OP_ORI  = 6'b001001,
        OP_ANDI = 6'b001010,
        OP_XORI = 6'b001011,
        OP_LDW  = 6'b001100,
        OP_STW  = 6'b001101,
        OP_BEQ  = 6'b001110,
        OP_BNE  = 6'b001111,
        OP_JMP  = 6'b010000,
        OP_HALT = 6'b010001
    } opcode_t;

    typedef enum logic [2:0] {
        CLS_ARITH   = 3'd0,
        CLS_LOGIC   = 3'd1,
        CLS_MEM     = 3'd2,
        CLS_CTRL    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } inst_class_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } stats_state_t;

    // Opcodes are allocated in contiguous ranges, so ordered compares suffice.
    function automatic inst_class_t classify(input logic [OPC_W-1:0] op);
        inst_class_t cls;
        if (op <= 6'b000101) begin
            cls = CLS_ARITH;
        end else if (op <= 6'b001011) begin
            cls = CLS_LOGIC;
        end else if (op <= 6'b001101) begin
            cls = CLS_MEM;
        end else if (op <= 6'b010001) begin
            cls = CLS_CTRL;
        end else begin
            cls = CLS_ILLEGAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/pipe_stats_unit_if.sv
// Retire-side inputs and statistics readout of the pipeline statistics unit.
interface pipe_stats_unit_if #(
    parameter int CNT_W   = 16,
    parameter int STALL_W = 32
);
    logic               retire_valid;
    logic [31:0]        retire_inst;
    logic [1:0]         stall_nofwd_inc;
    logic               stall_fwd_inc;
    logic [CNT_W-1:0]   arith_inst_cnt;
    logic [CNT_W-1:0]   logic_inst_cnt;
    logic [CNT_W-1:0]   mem_inst_cnt;
    logic [CNT_W-1:0]   ctrl_inst_cnt;
    logic [STALL_W-1:0] stall_wo_forewarding;
    logic [STALL_W-1:0] stall_w_forewarding;
    logic [STALL_W-1:0] cycle_cnt;
    logic               busy;
    logic               done;
    logic               illegal_op;

    modport master (
        output retire_valid, retire_inst, stall_nofwd_inc, stall_fwd_inc,
        input  arith_inst_cnt, logic_inst_cnt, mem_inst_cnt, ctrl_inst_cnt,
               stall_wo_forewarding, stall_w_forewarding, cycle_cnt,
               busy, done, illegal_op
    );

    modport slave (
        input  retire_valid, retire_inst, stall_nofwd_inc, stall_fwd_inc,
        output arith_inst_cnt, logic_inst_cnt, mem_inst_cnt, ctrl_inst_cnt,
               stall_wo_forewarding, stall_w_forewarding, cycle_cnt,
               busy, done, illegal_op
    );
endinterface

// File: rtl/pipe_stats_unit_sat_counter.sv
// Saturating accumulator: adds add_i when enabled and clamps at all-ones.
module sat_counter #(
    parameter int W     = 16,
    parameter int ADD_W = 1
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             en_i,
    input  logic [ADD_W-1:0] add_i,
    output logic [W-1:0]     cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum_s;

    // Carry out of the widened sum means the add would wrap, so clamp.
    always_comb begin
        sum_s = {1'b0, cnt_q} + (W+1)'(add_i);
        if (en_i) begin
            cnt_d = sum_s[W] ? {W{1'b1}} : sum_s[W-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stats_unit.sv
// Watches retiring instructions, accumulates class/stall/cycle statistics and
// freezes them once the halt instruction has retired and the pipe has drained.
module pipe_stats_unit
    import pipe_stats_unit_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int STALL_W      = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    pipe_stats_unit_if.slave bus
);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    stats_state_t        state_q, state_d;
    logic [DRAIN_W-1:0]  drain_ctr_q, drain_ctr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    logic                accept_s;
    logic                cycle_en_s;
    logic                is_halt_s;
    inst_class_t         cls_s;

    assign cls_s     = classify(bus.retire_inst[31:26]);
    assign is_halt_s = (bus.retire_inst[31:26] == OP_HALT);

    // State, drain counter and status flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            drain_ctr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_ctr_q <= drain_ctr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next-state logic; a halt retiring from IDLE skips straight to DRAIN.
    always_comb begin
        state_d     = state_q;
        drain_ctr_d = drain_ctr_q;
        case (state_q)
            IDLE, RUN: begin
                if (bus.retire_valid && is_halt_s) begin
                    state_d     = DRAIN;
                    drain_ctr_d = '0;
                end else if (bus.retire_valid) begin
                    state_d = RUN;
                end else begin
                    state_d = state_q;
                end
            end
            DRAIN: begin
                if (drain_ctr_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_ctr_d = drain_ctr_q + DRAIN_W'(1);
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Counter enables and next values of the registered status flags.
    always_comb begin
        accept_s   = 1'b0;
        cycle_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                accept_s   = bus.retire_valid;
                cycle_en_s = bus.retire_valid;
            end
            RUN: begin
                accept_s   = bus.retire_valid;
                cycle_en_s = 1'b1;
            end
            DRAIN:   cycle_en_s = 1'b1;
            default: cycle_en_s = 1'b0;
        endcase
        illegal_d = illegal_q | (accept_s && (cls_s == CLS_ILLEGAL));
        busy_d    = (state_d == RUN) || (state_d == DRAIN);
        done_d    = (state_d == DONE);
    end

    sat_counter #(.W(CNT_W), .ADD_W(1)) u_arith (
        .clk_i(clk), .clr_n_i(reset), .en_i(accept_s && (cls_s == CLS_ARITH)),
        .add_i(1'b1), .cnt_o(bus.arith_inst_cnt)
    );
    sat_counter #(.W(CNT_W), .ADD_W(1)) u_logic (
        .clk_i(clk), .clr_n_i(reset), .en_i(accept_s && (cls_s == CLS_LOGIC)),
        .add_i(1'b1), .cnt_o(bus.logic_inst_cnt)
    );
    sat_counter #(.W(CNT_W), .ADD_W(1)) u_mem (
        .clk_i(clk), .clr_n_i(reset), .en_i(accept_s && (cls_s == CLS_MEM)),
        .add_i(1'b1), .cnt_o(bus.mem_inst_cnt)
    );
    sat_counter #(.W(CNT_W), .ADD_W(1)) u_ctrl (
        .clk_i(clk), .clr_n_i(reset), .en_i(accept_s && (cls_s == CLS_CTRL)),
        .add_i(1'b1), .cnt_o(bus.ctrl_inst_cnt)
    );
    sat_counter #(.W(STALL_W), .ADD_W(2)) u_stall_nofwd (
        .clk_i(clk), .clr_n_i(reset), .en_i(accept_s),
        .add_i(bus.stall_nofwd_inc), .cnt_o(bus.stall_wo_forewarding)
    );
    sat_counter #(.W(STALL_W), .ADD_W(1)) u_stall_fwd (
        .clk_i(clk), .clr_n_i(reset), .en_i(accept_s),
        .add_i(bus.stall_fwd_inc), .cnt_o(bus.stall_w_forewarding)
    );
    sat_counter #(.W(STALL_W), .ADD_W(1)) u_cycle (
        .clk_i(clk), .clr_n_i(reset), .en_i(cycle_en_s),
        .add_i(1'b1), .cnt_o(bus.cycle_cnt)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_pipe_stats_unit.sv
// Scenario bench for pipe_stats_unit with a behavioural statistics model.
module tb_pipe_stats_unit;
    import pipe_stats_unit_pkg::*;

    localparam int CNT_W        = 16;
    localparam int STALL_W      = 32;
    localparam int DRAIN_CYCLES = 4;
    localparam longint CNT_MAX   = (longint'(1) << CNT_W) - 1;
    localparam longint STALL_MAX = (longint'(1) << STALL_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stats_unit_if #(.CNT_W(CNT_W), .STALL_W(STALL_W)) bus ();

    pipe_stats_unit #(.CNT_W(CNT_W), .STALL_W(STALL_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 running, 2 draining, 3 finished.
    longint m_arith, m_logic, m_mem, m_ctrl, m_swo, m_sw, m_cyc;
    bit     m_ill;
    int     m_phase, m_drain_left;

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_reset();
        m_arith = 0; m_logic = 0; m_mem = 0; m_ctrl = 0;
        m_swo = 0; m_sw = 0; m_cyc = 0; m_ill = 1'b0;
        m_phase = 0; m_drain_left = 0;
    endfunction

    function automatic void model_retire(input int op, input int nf, input int f);
        if (op < 6)       m_arith = sat(m_arith + 1, CNT_MAX);
        else if (op < 12) m_logic = sat(m_logic + 1, CNT_MAX);
        else if (op < 14) m_mem   = sat(m_mem + 1, CNT_MAX);
        else if (op < 18) m_ctrl  = sat(m_ctrl + 1, CNT_MAX);
        else              m_ill   = 1'b1;
        m_swo = sat(m_swo + nf, STALL_MAX);
        m_sw  = sat(m_sw + f, STALL_MAX);
        if (op == 17) begin
            m_phase      = 2;
            m_drain_left = DRAIN_CYCLES;
        end else begin
            m_phase = 1;
        end
    endfunction

    function automatic void model_step(input bit v, input int op, input int nf, input int f);
        if (m_phase == 0) begin
            if (v) begin
                m_cyc = sat(m_cyc + 1, STALL_MAX);
                model_retire(op, nf, f);
            end
        end else if (m_phase == 1) begin
            m_cyc = sat(m_cyc + 1, STALL_MAX);
            if (v) model_retire(op, nf, f);
        end else if (m_phase == 2) begin
            m_cyc = sat(m_cyc + 1, STALL_MAX);
            m_drain_left--;
            if (m_drain_left == 0) m_phase = 3;
        end
    endfunction

    task automatic step(input bit v, input logic [5:0] op, input logic [1:0] nf, input bit f);
        bus.retire_valid    = v;
        bus.retire_inst     = {op, 26'($urandom)};
        bus.stall_nofwd_inc = nf;
        bus.stall_fwd_inc   = f;
        @(posedge clk);
        model_step(v, int'(op), int'(nf), int'(f));
        #1;
        bus.retire_valid    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.arith_inst_cnt, bus.logic_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_class_cnt: got %0h want 0",
                     {bus.arith_inst_cnt, bus.logic_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt});
        end
        n_cmp++;
        if ({bus.stall_wo_forewarding, bus.stall_w_forewarding, bus.cycle_cnt} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_stall_cycle: got %0h want 0",
                     {bus.stall_wo_forewarding, bus.stall_w_forewarding, bus.cycle_cnt});
        end
        n_cmp++;
        if ({bus.busy, bus.done, bus.illegal_op} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.illegal_op});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, OP_ADD, 2'd0, 1'b0);
        step(1'b1, OP_ORI, 2'd0, 1'b0);
        step(1'b1, OP_LDW, 2'd0, 1'b0);
        step(1'b1, OP_BEQ, 2'd0, 1'b0);
        step(1'b1, OP_HALT, 2'd0, 1'b0);
        n_cmp++;
        if ({bus.arith_inst_cnt, bus.logic_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt}
            !== {16'd1, 16'd1, 16'd1, 16'd2}) begin
            n_bad++;
            $display("FAIL b2b_classes: got %0h want 0001000100010002",
                     {bus.arith_inst_cnt, bus.logic_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt});
        end
        for (int i = 1; i <= DRAIN_CYCLES; i++) begin
            n_cmp++;
            if (bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_done_early: cycle %0d got %b want 0", i, bus.done);
            end
            step(1'b0, OP_ADD, 2'd0, 1'b0);
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
        end
        n_cmp++;
        if (bus.cycle_cnt !== 32'd9) begin
            n_bad++;
            $display("FAIL b2b_cycle_cnt: got %0d want 9", bus.cycle_cnt);
        end
    endtask

    task automatic test_stalls();
        do_reset();
        step(1'b1, OP_ADD, 2'd2, 1'b1);
        step(1'b1, OP_LDW, 2'd1, 1'b0);
        step(1'b1, OP_OR,  2'd2, 1'b1);
        step(1'b1, OP_HALT, 2'd0, 1'b0);
        n_cmp++;
        if (bus.stall_wo_forewarding !== 32'd5) begin
            n_bad++;
            $display("FAIL stall_nofwd: got %0d want 5", bus.stall_wo_forewarding);
        end
        n_cmp++;
        if (bus.stall_w_forewarding !== 32'd2) begin
            n_bad++;
            $display("FAIL stall_fwd: got %0d want 2", bus.stall_w_forewarding);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        step(1'b1, 6'b111111, 2'd1, 1'b1);
        n_cmp++;
        if (bus.illegal_op !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_flag: got %b want 1", bus.illegal_op);
        end
        step(1'b1, OP_HALT, 2'd0, 1'b0);
        n_cmp++;
        if ({bus.arith_inst_cnt, bus.logic_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt}
            !== {16'd0, 16'd0, 16'd0, 16'd1}) begin
            n_bad++;
            $display("FAIL illegal_classes: got %0h want 0000000000000001",
                     {bus.arith_inst_cnt, bus.logic_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt});
        end
        n_cmp++;
        if (bus.stall_wo_forewarding !== 32'd1 || bus.stall_w_forewarding !== 32'd1) begin
            n_bad++;
            $display("FAIL illegal_stalls: got %0d/%0d want 1/1",
                     bus.stall_wo_forewarding, bus.stall_w_forewarding);
        end
    endtask

    task automatic test_halt_first();
        do_reset();
        step(1'b1, OP_HALT, 2'd0, 1'b0);
        n_cmp++;
        if (bus.ctrl_inst_cnt !== 16'd1 || bus.cycle_cnt !== 32'd1 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_first: got ctrl=%0d cyc=%0d busy=%b want 1/1/1",
                     bus.ctrl_inst_cnt, bus.cycle_cnt, bus.busy);
        end
        repeat (DRAIN_CYCLES) step(1'b0, OP_ADD, 2'd0, 1'b0);
        n_cmp++;
        if (bus.done !== 1'b1 || bus.cycle_cnt !== 32'd5) begin
            n_bad++;
            $display("FAIL halt_first_done: got done=%b cyc=%0d want 1/5", bus.done, bus.cycle_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (65534) step(1'b1, OP_ADD, 2'd0, 1'b0);
        n_cmp++;
        if (bus.arith_inst_cnt !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sat_preload: got %0h want fffe", bus.arith_inst_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, OP_ADD, 2'd0, 1'b0);
            n_cmp++;
            if (bus.arith_inst_cnt !== CNT_W'(m_arith)) begin
                n_bad++;
                $display("FAIL sat_hold: step %0d got %0h want %0h", i, bus.arith_inst_cnt, m_arith);
            end
        end
        n_cmp++;
        if (bus.arith_inst_cnt !== 16'hFFFF || bus.cycle_cnt !== 32'd65538) begin
            n_bad++;
            $display("FAIL sat_final: got arith=%0h cyc=%0d want ffff/65538", bus.arith_inst_cnt, bus.cycle_cnt);
        end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        step(1'b1, OP_ADD, 2'd2, 1'b1);
        step(1'b1, OP_HALT, 2'd0, 1'b0);
        step(1'b0, OP_ADD, 2'd0, 1'b0);
        step(1'b0, OP_ADD, 2'd0, 1'b0);
        do_reset();
        n_cmp++;
        if ({bus.arith_inst_cnt, bus.ctrl_inst_cnt, bus.stall_wo_forewarding, bus.stall_w_forewarding,
             bus.cycle_cnt, bus.busy, bus.done, bus.illegal_op} !== '0) begin
            n_bad++;
            $display("FAIL drain_reset: got arith=%0d ctrl=%0d cyc=%0d busy=%b done=%b want all 0",
                     bus.arith_inst_cnt, bus.ctrl_inst_cnt, bus.cycle_cnt, bus.busy, bus.done);
        end
        step(1'b1, OP_ADD, 2'd0, 1'b0);
        n_cmp++;
        if (bus.arith_inst_cnt !== 16'd1 || bus.busy !== 1'b1 || bus.cycle_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL drain_reset_restart: got arith=%0d busy=%b cyc=%0d want 1/1/1",
                     bus.arith_inst_cnt, bus.busy, bus.cycle_cnt);
        end
    endtask

    task automatic test_ignore_after_halt();
        do_reset();
        step(1'b1, OP_ADD, 2'd1, 1'b0);
        step(1'b1, OP_HALT, 2'd0, 1'b0);
        step(1'b1, OP_ADD, 2'd2, 1'b1);
        step(1'b1, OP_ADD, 2'd2, 1'b1);
        step(1'b1, 6'b111111, 2'd2, 1'b1);
        step(1'b1, OP_LDW, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.done !== 1'b1) begin
                n_bad++;
                $display("FAIL frozen_done: pulse %0d got %b want 1", i, bus.done);
            end
            step(1'b1, (i == 1) ? 6'b111111 : OP_ADD, 2'd2, 1'b1);
        end
        n_cmp++;
        if ({bus.arith_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt} !== {16'd1, 16'd0, 16'd1}) begin
            n_bad++;
            $display("FAIL frozen_classes: got %0h want 000100000001",
                     {bus.arith_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt});
        end
        n_cmp++;
        if (bus.stall_wo_forewarding !== 32'd1 || bus.stall_w_forewarding !== 32'd0
            || bus.cycle_cnt !== 32'd6 || bus.illegal_op !== 1'b0) begin
            n_bad++;
            $display("FAIL frozen_stats: got swo=%0d sw=%0d cyc=%0d ill=%b want 1/0/6/0",
                     bus.stall_wo_forewarding, bus.stall_w_forewarding, bus.cycle_cnt, bus.illegal_op);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n_inst;
            n_inst = int'($urandom_range(5, 40));
            do_reset();
            for (int k = 0; k < n_inst + DRAIN_CYCLES + 4; k++) begin
                bit         v;
                logic [5:0] op;
                v  = ($urandom_range(0, 3) != 0);
                op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(18, 63)) : 6'($urandom_range(0, 16));
                if (k == n_inst) begin
                    v  = 1'b1;
                    op = OP_HALT;
                end
                step(v, op, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                n_cmp++;
                if (bus.arith_inst_cnt !== CNT_W'(m_arith) || bus.logic_inst_cnt !== CNT_W'(m_logic)
                    || bus.mem_inst_cnt !== CNT_W'(m_mem) || bus.ctrl_inst_cnt !== CNT_W'(m_ctrl)) begin
                    n_bad++;
                    $display("FAIL rand_classes: r%0d k%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", r, k,
                             bus.arith_inst_cnt, bus.logic_inst_cnt, bus.mem_inst_cnt, bus.ctrl_inst_cnt,
                             m_arith, m_logic, m_mem, m_ctrl);
                end
                n_cmp++;
                if (bus.stall_wo_forewarding !== STALL_W'(m_swo) || bus.stall_w_forewarding !== STALL_W'(m_sw)
                    || bus.cycle_cnt !== STALL_W'(m_cyc)) begin
                    n_bad++;
                    $display("FAIL rand_stall_cycle: r%0d k%0d got %0d/%0d/%0d want %0d/%0d/%0d", r, k,
                             bus.stall_wo_forewarding, bus.stall_w_forewarding, bus.cycle_cnt,
                             m_swo, m_sw, m_cyc);
                end
                n_cmp++;
                if (bus.busy !== (m_phase == 1 || m_phase == 2) || bus.done !== (m_phase == 3)
                    || bus.illegal_op !== m_ill) begin
                    n_bad++;
                    $display("FAIL rand_flags: r%0d k%0d got busy=%b done=%b ill=%b want phase %0d ill=%b",
                             r, k, bus.busy, bus.done, bus.illegal_op, m_phase, m_ill);
                end
            end
        end
    endtask

    initial begin
        reset               = 1'b0;
        bus.retire_valid    = 1'b0;
        bus.retire_inst     = 32'h0;
        bus.stall_nofwd_inc = 2'd0;
        bus.stall_fwd_inc   = 1'b0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_stalls();
        test_illegal();
        test_halt_first();
        test_reset_in_drain();
        test_ignore_after_halt();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
